// File: rtl/inst_fetch_pkg.sv
// Shared core definitions: instruction constants, base opcodes and the
// fetch-stage state encoding used by the fetch stage and by decode.
package inst_fetch_pkg;

  // Canonical no-op: addi x0, x0, 0
  localparam logic [31:0] NOP = 32'h0000_0013;

  // Default PC loaded on reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // RV32I base opcodes (bits [6:0]), shared with decode and immediate gen
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Fetch stage states
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // issuing reads, delivering into IF/ID
    ST_HOLD  = 2'd1,  // decode stalled, fetched word parked in the skid
    ST_DRAIN = 2'd2   // redirect arrived during a cache stall; wait it out
  } fetch_state_t;

  // Word-aligned version of a jump/branch target
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/inst_fetch_skid.sv
// One-entry holding register for a fetched pc/instruction pair that decode
// could not accept. Clear wins over load.
module inst_fetch_skid
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] inst
);

  logic        valid_reg;
  logic [31:0] pc_reg;
  logic [31:0] inst_reg;

  // Capture on load, empty on clear or reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      pc_reg    <= 32'd0;
      inst_reg  <= NOP;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      pc_reg    <= load_pc;
      inst_reg  <= load_inst;
    end
  end

  assign valid = valid_reg;
  assign pc    = pc_reg;
  assign inst  = inst_reg;

endmodule

// File: rtl/inst_fetch.sv
// RV32I instruction fetch stage with IF/ID pipeline register. Owns the PC,
// issues word reads, absorbs cache stalls and decode back-pressure, and
// applies redirects from EX.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic        INST_SWAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        ic_read,
  output logic [29:0] ic_addr,
  input  logic        ic_stall,
  input  logic [31:0] ic_rdata,
  input  logic        id_stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic [31:0] ifid_inst
);

  fetch_state_t state_reg, state_next;

  logic [31:0] pc_reg, pc_next;
  logic [31:0] pend_pc_reg, pend_pc_next;
  logic        ifid_valid_reg, ifid_valid_next;
  logic [31:0] ifid_pc_reg, ifid_pc_next;
  logic [31:0] ifid_pc_plus4_reg, ifid_pc_plus4_next;
  logic [31:0] ifid_inst_reg, ifid_inst_next;

  logic        skid_load, skid_clear;
  logic        skid_valid;
  logic [31:0] skid_pc, skid_inst;

  logic [31:0] fetch_word;
  logic [31:0] pc_plus4;
  logic [31:0] redirect_target;
  logic [31:0] drain_target;

  // Memory is little-endian; optionally reverse bytes of the returned word
  generate
    if (INST_SWAP) begin : g_swap
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign fetch_word[8*gi +: 8] = ic_rdata[8*(3-gi) +: 8];
      end
    end else begin : g_pass
      assign fetch_word = ic_rdata;
    end
  endgenerate

  assign pc_plus4        = pc_reg + 32'd4;
  assign redirect_target = align_word(redirect_pc);
  assign drain_target    = redirect ? redirect_target : pend_pc_reg;

  // Request side depends only on state and pc (plus reset gating)
  assign ic_read = rst_n && (state_reg != ST_HOLD);
  assign ic_addr = pc_reg[31:2];

  inst_fetch_skid u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (skid_load),
    .clear     (skid_clear),
    .load_pc   (pc_reg),
    .load_inst (fetch_word),
    .valid     (skid_valid),
    .pc        (skid_pc),
    .inst      (skid_inst)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state, pc and IF/ID update; redirect outranks everything else
  always_comb begin
    state_next         = state_reg;
    pc_next            = pc_reg;
    pend_pc_next       = pend_pc_reg;
    ifid_valid_next    = ifid_valid_reg;
    ifid_pc_next       = ifid_pc_reg;
    ifid_pc_plus4_next = ifid_pc_plus4_reg;
    ifid_inst_next     = ifid_inst_reg;
    skid_load          = 1'b0;
    skid_clear         = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        if (redirect) begin
          ifid_valid_next = 1'b0;
          ifid_inst_next  = NOP;
          skid_clear      = 1'b1;
          if (ic_stall) begin
            // Outstanding read must finish first; remember where to go
            pend_pc_next = redirect_target;
            state_next   = ST_DRAIN;
          end else begin
            // Word returned this cycle is on the wrong path; drop it
            pc_next = redirect_target;
          end
        end else if (!ic_stall) begin
          if (id_stall) begin
            skid_load  = 1'b1;
            state_next = ST_HOLD;
          end else begin
            ifid_valid_next    = 1'b1;
            ifid_pc_next       = pc_reg;
            ifid_pc_plus4_next = pc_plus4;
            ifid_inst_next     = fetch_word;
            pc_next            = pc_plus4;
          end
        end else if (!id_stall) begin
          // Decode took the old entry and nothing new arrived: bubble
          ifid_valid_next = 1'b0;
          ifid_inst_next  = NOP;
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_next         = redirect_target;
          skid_clear      = 1'b1;
          ifid_valid_next = 1'b0;
          ifid_inst_next  = NOP;
          state_next      = ST_FETCH;
        end else if (!id_stall) begin
          ifid_valid_next    = skid_valid;
          ifid_pc_next       = skid_pc;
          ifid_pc_plus4_next = skid_pc + 32'd4;
          ifid_inst_next     = skid_inst;
          pc_next            = pc_plus4;
          skid_clear         = 1'b1;
          state_next         = ST_FETCH;
        end
      end

      ST_DRAIN: begin
        if (redirect) begin
          ifid_valid_next = 1'b0;
          ifid_inst_next  = NOP;
        end
        if (!ic_stall) begin
          // Stale word discarded; jump to the most recent target
          pc_next    = drain_target;
          state_next = ST_FETCH;
        end else begin
          pend_pc_next = drain_target;
        end
      end

      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // Datapath registers: pc, pending target and IF/ID
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_reg            <= RESET_PC;
      pend_pc_reg       <= RESET_PC;
      ifid_valid_reg    <= 1'b0;
      ifid_pc_reg       <= 32'd0;
      ifid_pc_plus4_reg <= 32'd0;
      ifid_inst_reg     <= NOP;
    end else begin
      pc_reg            <= pc_next;
      pend_pc_reg       <= pend_pc_next;
      ifid_valid_reg    <= ifid_valid_next;
      ifid_pc_reg       <= ifid_pc_next;
      ifid_pc_plus4_reg <= ifid_pc_plus4_next;
      ifid_inst_reg     <= ifid_inst_next;
    end
  end

  assign ifid_valid    = ifid_valid_reg;
  assign ifid_pc       = ifid_pc_reg;
  assign ifid_pc_plus4 = ifid_pc_plus4_reg;
  assign ifid_inst     = ifid_inst_reg;

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction-fetch stage and IF/ID pipeline register of the RV32I core. Owns the PC, issues word reads to the instruction cache, absorbs cache stalls and decode back-pressure, and applies taken-branch/jump redirects from EX. Its IF/ID outputs feed decode, which drives the immediate generator and register file.

## Interface

- RESET_PC, 32'h0000_0000, PC loaded on reset
- INST_SWAP, 1, 1 = byte-reverse ic_rdata (little-endian memory) before use; 0 = pass through

- clk  in  1  core clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- ic_read  out  1  fetch request to instruction cache
- ic_addr  out  30  word address, = pc[31:2]
- ic_stall  in  1  cache busy; request and address must be held while high
- ic_rdata  in  32  instruction word, valid in any cycle with ic_read=1 and ic_stall=0
- id_stall  in  1  decode cannot accept; IF/ID holds
- redirect  in  1  EX redirect (taken branch, jal, jalr)
- redirect_pc  in  32  redirect target
- ifid_valid  out  1  IF/ID holds a real instruction
- ifid_pc  out  32  PC of ifid_inst
- ifid_pc_plus4  out  32  ifid_pc + 4 (link value for jal/jalr)
- ifid_inst  out  32  instruction to decode (NOP 32'h0000_0013 when invalid)

## Operation

- States: FETCH, HOLD, DRAIN.
- Reset (rst_n=0 at a clock edge): pc=RESET_PC, state=FETCH, skid empty, ifid_valid=0, ifid_pc=0, ifid_pc_plus4=0, ifid_inst=NOP. ic_read=0 while rst_n=0.
- ic_read = 1 in FETCH and DRAIN (rst_n=1), 0 in HOLD. ic_addr always pc[31:2].
- "Complete" = ic_read=1 and ic_stall=0.
- FETCH, complete, no redirect, id_stall=0: IF/ID <= {1, pc, pc+4, inst}; pc <= pc+4; stay FETCH.
- FETCH, complete, id_stall=1: inst and pc captured in skid; IF/ID unchanged; -> HOLD.
- FETCH, ic_stall=1: pc, ic_addr held; IF/ID loads nothing new (if id_stall=0, ifid_valid <= 0, ifid_inst <= NOP).
- HOLD, id_stall=0: IF/ID <= skid; pc <= pc+4; skid empty; -> FETCH.
- Redirect (highest priority, overrides id_stall):
  - FETCH with ic_stall=0, or HOLD: pc <= {redirect_pc[31:2],2'b00}; skid discarded; IF/ID flushed (valid=0, inst=NOP); -> FETCH. Returned word that cycle discarded.
  - FETCH with ic_stall=1: latch target in pend_pc, flush IF/ID, -> DRAIN.
- DRAIN: address held until complete; returned word discarded; then pc <= pend_pc, -> FETCH. Second redirect in DRAIN overwrites pend_pc.
- id_stall while no completion: IF/ID holds unchanged.
- pc+4 wraps modulo 2^32; redirect_pc[1:0] ignored (cleared).
- Reset mid-stall or mid-DRAIN: all state reinitialised; pending target and skid lost.

## Timing

- No stalls: ic_read at cycle t with ic_stall=0 -> ifid_* valid after edge t+1; one instruction per cycle.
- Redirect asserted at t (not in DRAIN path): ic_addr = target at t+1, its instruction in IF/ID at t+2; two bubbles.
- Redirect during cache stall: target issued the cycle after ic_stall falls.
- HOLD exit: skid in IF/ID the cycle after id_stall falls; next fetch issued that cycle.
- All outputs except ic_read/ic_addr registered; ic_read/ic_addr derived from state and pc only (no input-to-output combinational path).

## Structure

- Shared core package: NOP constant 32'h0000_0013, RESET_PC default, opcode constants (shared with decode/immediate generation), fetch state encoding.
- One sub-module natural: fetch_skid (one-entry pc+inst holding register with load/clear/valid).

## Test plan

- Reset, RESET_PC=0, ic_stall=0, memory word[i]=i: ifid_pc 0,4,8,… on consecutive cycles, ifid_inst matching (with INST_SWAP=1, raw 32'h1300_0000 -> 32'h0000_0013).
- ic_stall high 3 cycles on fetch of pc=8: ic_addr=2 held 3 cycles, ifid_valid=0 for 3 cycles, then pc 8 delivered once.
- id_stall high 2 cycles at pc=4 complete: IF/ID holds pc 0, state HOLD, ic_read=0; pc 4 appears cycle after id_stall drops, no duplicates/skips.
- redirect to 32'h100 with ic_stall=0: next ic_addr=32'h40, IF/ID flushed to NOP, pc 32'h100 valid two cycles after redirect.
- redirect to 32'h200 during ic_stall: address unchanged until stall ends, stale word discarded, then ic_addr=32'h80; redirect+id_stall together: flush wins.
- pc=32'hFFFF_FFFC fetched: next ic_addr=0; rst_n low during DRAIN: pc=RESET_PC, ifid_valid=0 next cycle.
